// File: rtl/screen_sequencer.sv
// Commits a debounced screen code to the renderer and sequences the LED strip frames.
// Every screen change is framed by a blank frame and a settle gap; stable screens are refreshed.
module screen_sequencer #(
    parameter int unsigned REFRESH_CYCLES = 1_000_000,
    parameter int unsigned SETTLE_CYCLES  = 1000,
    parameter int unsigned STABLE_CYCLES  = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [1:0] current_screen_i,
    input  logic       frame_done_i,
    output logic       frame_req_o,
    output logic       frame_clear_o,
    output logic [1:0] active_screen_o,
    output logic       screen_changed_o
);
    localparam int unsigned RefW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int unsigned SetW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned StbW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

    localparam logic [RefW-1:0] RefreshLast = RefW'(REFRESH_CYCLES - 1);
    localparam logic [SetW-1:0] SettleLast  = SetW'(SETTLE_CYCLES - 1);
    localparam logic [StbW-1:0] StableLast  = StbW'(STABLE_CYCLES - 1);

    localparam logic [1:0] StClear  = 2'd0;
    localparam logic [1:0] StSettle = 2'd1;
    localparam logic [1:0] StRun    = 2'd2;
    localparam logic [1:0] StRender = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [RefW-1:0] timer_q, timer_d;
    logic [SetW-1:0] settle_q, settle_d;
    logic [1:0]      cand_q, cand_d;
    logic [StbW-1:0] stb_q, stb_d;
    logic [1:0]      active_q, active_d;
    logic            changed_q, changed_d;
    logic            req_q, req_d;
    logic            clear_q, clear_d;
    logic            done_ok;
    logic            pending;

    // Stability filter runs in every state so changes queue up while a frame is in flight.
    always_comb begin
        cand_d = cand_q;
        stb_d  = stb_q;
        if (current_screen_i != cand_q) begin
            cand_d = current_screen_i;
            stb_d  = '0;
        end else if (stb_q != StableLast) begin
            stb_d = stb_q + 1'b1;
        end
    end

    assign pending = (stb_q == StableLast) && (cand_q != active_q);
    assign done_ok = req_q && frame_done_i;

    always_comb begin
        state_d   = state_q;
        timer_d   = '0;
        settle_d  = '0;
        active_d  = active_q;
        changed_d = 1'b0;
        case (state_q)
            StClear: begin
                if (done_ok) state_d = StSettle;
            end
            StSettle: begin
                if (settle_q == SettleLast) state_d = StRun;
                else settle_d = settle_q + 1'b1;
            end
            StRun: begin
                if (pending) begin
                    active_d  = cand_q;
                    changed_d = 1'b1;
                    state_d   = StClear;
                end else if (timer_q == RefreshLast) begin
                    state_d = StRender;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StRender: begin
                if (done_ok) state_d = StRun;
            end
            default: state_d = StClear;
        endcase
        // Request is registered from the current state, so it rises one cycle after entry.
        req_d   = ((state_q == StClear) || (state_q == StRender)) && !done_ok;
        clear_d = (state_q == StClear) && !done_ok;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= StClear;
            timer_q   <= '0;
            settle_q  <= '0;
            cand_q    <= 2'b00;
            stb_q     <= '0;
            active_q  <= 2'b00;
            changed_q <= 1'b0;
            req_q     <= 1'b0;
            clear_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            settle_q  <= settle_d;
            cand_q    <= cand_d;
            stb_q     <= stb_d;
            active_q  <= active_d;
            changed_q <= changed_d;
            req_q     <= req_d;
            clear_q   <= clear_d;
        end
    end

    assign frame_req_o      = req_q;
    assign frame_clear_o    = clear_q;
    assign active_screen_o  = active_q;
    assign screen_changed_o = changed_q;
endmodule

// File: tb/tb_screen_sequencer.sv
// Scoreboard bench for screen_sequencer: stimulus queues expected frame/change events,
// a negedge monitor pops and compares them, including cycle gaps from the last reference point.
module tb_screen_sequencer;
    logic       clk;
    logic       reset;
    logic [1:0] screen;
    logic       done_resp;
    logic       done_spur;
    logic       frame_req;
    logic       frame_clear;
    logic [1:0] active;
    logic       changed;

    screen_sequencer #(
        .REFRESH_CYCLES(20),
        .SETTLE_CYCLES (5),
        .STABLE_CYCLES (3)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .current_screen_i(screen),
        .frame_done_i    (done_resp | done_spur),
        .frame_req_o     (frame_req),
        .frame_clear_o   (frame_clear),
        .active_screen_o (active),
        .screen_changed_o(changed)
    );

    // kind 0 = frame request rise, kind 1 = screen_changed pulse
    typedef struct {
        int kind;
        int clr;
        int act;
        int gap;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   ref_cyc = 0;
    int   ev_count = 0;
    int   done_count = 0;
    logic prev_req = 1'b0;
    logic prev_done = 1'b0;
    logic prev_reset = 1'b1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d at cycle %0d", name, got, want, cyc);
        end
    endfunction

    task automatic push(input int kind, input int clr, input int act, input int gap);
        exp_t e;
        e.kind = kind;
        e.clr  = clr;
        e.act  = act;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    // LED driver model: answers 10 cycles after the request rises, drops abandoned requests.
    initial begin
        int rcnt;
        rcnt = 0;
        done_resp = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (done_resp) begin
                done_resp = 1'b0;
                rcnt = 0;
            end else if (frame_req) begin
                rcnt++;
                if (rcnt == 11) done_resp = 1'b1;
            end else begin
                rcnt = 0;
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            ref_cyc = cyc;
        end else begin
            if (frame_req && !prev_req) begin
                ev_count++;
                if (exp_q.size() == 0) begin
                    chk("unexpected frame", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame kind", 0, e.kind);
                    chk("frame_clear", int'(frame_clear), e.clr);
                    chk("frame active_screen", int'(active), e.act);
                    chk("frame gap", cyc - ref_cyc, e.gap);
                end
                ref_cyc = cyc;
            end
            if (changed) begin
                ev_count++;
                if (exp_q.size() == 0) begin
                    chk("unexpected screen_changed", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("change kind", 1, e.kind);
                    chk("change active_screen", int'(active), e.act);
                    chk("change gap", cyc - ref_cyc, e.gap);
                end
                ref_cyc = cyc;
            end
            if (frame_req && (done_resp | done_spur)) begin
                done_count++;
                ref_cyc = cyc;
            end
            if (prev_req && !frame_req) chk("req held until done", int'(prev_done || prev_reset), 1);
        end
        prev_req   = frame_req;
        prev_done  = frame_req && (done_resp | done_spur);
        prev_reset = reset;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input int n);
        int t;
        t = 0;
        while (done_count < n && t < 300) begin
            tick(1);
            t++;
        end
        chk("wait frame_done count", done_count >= n ? n : done_count, n);
    endtask

    task automatic wait_ev(input int n);
        int t;
        t = 0;
        while (ev_count < n && t < 300) begin
            tick(1);
            t++;
        end
        chk("wait event count", ev_count >= n ? n : ev_count, n);
    endtask

    task automatic chk_reset_outputs();
        chk("reset frame_req", int'(frame_req), 0);
        chk("reset frame_clear", int'(frame_clear), 0);
        chk("reset active_screen", int'(active), 0);
        chk("reset screen_changed", int'(changed), 0);
    endtask

    initial begin
        reset = 1'b1;
        screen = 2'b00;
        done_spur = 1'b0;
        tick(3);
        chk_reset_outputs();

        // Boot: blank frame, settle, then refresh renders every 20 RUN cycles
        push(0, 1, 0, 2);
        push(0, 0, 0, 27);
        push(0, 0, 0, 22);
        reset = 1'b0;

        // Glitch to 10 for two cycles then back: must be dropped
        wait_done(2);
        tick(2);
        screen = 2'b10;
        tick(2);
        screen = 2'b00;

        // Held change to 01 during RUN
        push(1, 0, 1, 7);
        push(0, 1, 1, 1);
        push(0, 0, 1, 27);
        wait_done(3);
        tick(2);
        screen = 2'b01;

        // Change to 10 while the render frame is in flight
        push(1, 0, 2, 2);
        push(0, 1, 2, 1);
        push(0, 0, 2, 27);
        wait_ev(6);
        screen = 2'b10;

        // Spurious frame_done in SETTLE and in RUN after the blank frame
        wait_done(6);
        tick(1);
        done_spur = 1'b1;
        tick(1);
        done_spur = 1'b0;
        tick(7);
        done_spur = 1'b1;
        tick(1);
        done_spur = 1'b0;

        // Reset during a render frame; code 11 is then committed after the boot blank
        wait_ev(9);
        tick(2);
        reset = 1'b1;
        screen = 2'b11;
        tick(1);
        chk_reset_outputs();
        push(0, 1, 0, 2);
        push(1, 0, 3, 7);
        push(0, 1, 3, 1);
        push(0, 0, 3, 27);
        tick(1);
        reset = 1'b0;

        wait_done(9);
        tick(3);
        chk("expected events left", exp_q.size(), 0);
        chk("final active_screen", int'(active), 3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
